ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- Parametrised EX/MEM pipeline stage between ALU/branch-adder (EX) and data memory (MEM); next generation of the fixed-width EX/MEM register.
- Adds valid/ready handshake with 2-entry skid buffer so MEM back-pressure does not lose in-flight instructions.
- Adds synchronous reset, flush (branch taken), x0-aware forwarding outputs and a saturating stall counter.

Parameters:
- XLEN, 64, width of ALU result and store data.
- PC_W, 8, width of branch target.
- RA_W, 5, register address width.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  branch taken (PCsrc); kill stage contents.
- in_valid  in  1  EX presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_alu_data  in  XLEN  ALU result / address.
- in_store_data  in  XLEN  rs2 value for stores.
- in_branch_target  in  PC_W  branch adder result.
- in_zero  in  1  ALU zero flag.
- in_rd  in  RA_W  destination register.
- in_memtoreg, in_regwrite, in_branch, in_memread, in_memwrite  in  1 each  control bits.
- out_valid  out  1  stage holds a valid instruction.
- out_ready  in  1  MEM consumes this cycle.
- out_alu_data, out_store_data, out_branch_target, out_zero, out_rd  out  widths as inputs  registered payload.
- out_memtoreg, out_regwrite, out_branch, out_memread, out_memwrite  out  1 each  registered control, gated.
- fwd_rd  out  RA_W  rd for forwarding unit.
- fwd_regwrite  out  1  forwarding-qualified write enable.
- stall_cycles  out  CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset (rst=1): state EMPTY; all outputs 0; stall_cycles=0; in_ready=0 during the rst cycle, 1 in the first cycle after.
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- States: EMPTY (main invalid), FULL (main valid, skid empty), SKID (main and skid valid).
- in_ready = 1 in EMPTY and FULL, 0 in SKID; derived from registered state only, no combinational path from out_ready.
- out_valid = 1 in FULL and SKID.
- EMPTY: accept -> FULL, main <= input.
- FULL: accept&drain -> FULL, main <= input; accept&!drain -> SKID, skid <= input; !accept&drain -> EMPTY; else hold.
- SKID: drain -> FULL, main <= skid; else hold.
- Latency: input accepted at edge N appears on out_* after edge N (1 cycle). Order is strictly FIFO; no loss or duplication.
- flush=1 (rst=0): next state EMPTY; both entries invalidated; any same-cycle input discarded. Flush beats accept and drain.
- Control gating: out_memtoreg, out_regwrite, out_branch, out_memread, out_memwrite are 0 whenever out_valid=0.
- Data outputs (alu, store, target, zero, rd) hold last main value when invalid; not checked when invalid.
- fwd_rd = out_rd.
- fwd_regwrite = out_valid & out_regwrite & (out_rd != 0); x0 is never forwarded.
- stall_cycles increments by 1 on each edge where out_valid&!out_ready; saturates at 2^CNT_W-1. Cleared only by rst; unaffected by flush.
- rst takes priority over flush and all handshakes, including mid-SKID.

Test Plan:
- Streaming: in_valid=1 and out_ready=1 for 4 instructions with alu=10,20,30,40 -> out_valid from cycle 1; outputs 10,20,30,40 on consecutive cycles; in_ready stays 1.
- Back-pressure: send A (alu=5), B (alu=6) with out_ready=0 -> state SKID; in_ready=0; stall_cycles=2 after 2 stalled edges; raise out_ready -> A then B drained in order; in_ready returns to 1.
- Flush in SKID: flush=1 with in_valid=1 (alu=7) -> next cycle out_valid=0, all control outputs 0; input 7 never appears at the output.
- x0 forwarding: input rd=0 with regwrite=1 -> out_regwrite=1, fwd_regwrite=0. Input rd=3 with regwrite=1 -> fwd_regwrite=1, fwd_rd=3.
- Reset mid-operation: assert rst in SKID with stall_cycles=9 -> next cycle all outputs 0, stall_cycles=0, in_ready=1 once rst is low.
- Counter saturation: CNT_W=2; hold out_valid=1 and out_ready=0 for 6 cycles -> stall_cycles sticks at 3.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Latency 1 cycle; in_ready drops only when both entries are full (no comb path from out_ready).
module ex_mem_stage #(
  parameter int XLEN  = 64,
  parameter int PC_W  = 8,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_alu_data,
  input  logic [XLEN-1:0]  in_store_data,
  input  logic [PC_W-1:0]  in_branch_target,
  input  logic             in_zero,
  input  logic [RA_W-1:0]  in_rd,
  input  logic             in_memtoreg,
  input  logic             in_regwrite,
  input  logic             in_branch,
  input  logic             in_memread,
  input  logic             in_memwrite,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_alu_data,
  output logic [XLEN-1:0]  out_store_data,
  output logic [PC_W-1:0]  out_branch_target,
  output logic             out_zero,
  output logic [RA_W-1:0]  out_rd,
  output logic             out_memtoreg,
  output logic             out_regwrite,
  output logic             out_branch,
  output logic             out_memread,
  output logic             out_memwrite,
  output logic [RA_W-1:0]  fwd_rd,
  output logic             fwd_regwrite,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] FULL  = 2'd1;
  localparam logic [1:0] SKID  = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] alu_data;
    logic [XLEN-1:0] store_data;
    logic [PC_W-1:0] branch_target;
    logic            zero;
    logic [RA_W-1:0] rd;
    logic            memtoreg;
    logic            regwrite;
    logic            branch;
    logic            memread;
    logic            memwrite;
  } entry_t;

  logic [1:0] state;
  entry_t     main_q;
  entry_t     skid_q;
  entry_t     in_ent;
  logic       accept;
  logic       drain;

  assign in_ent = '{alu_data: in_alu_data, store_data: in_store_data,
                    branch_target: in_branch_target, zero: in_zero, rd: in_rd,
                    memtoreg: in_memtoreg, regwrite: in_regwrite, branch: in_branch,
                    memread: in_memread, memwrite: in_memwrite};

  // rst is the only combinational term so the first post-reset cycle can accept
  assign in_ready  = ~rst & (state != SKID);
  assign out_valid = (state == FULL) || (state == SKID);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= EMPTY;
      main_q       <= '0;
      skid_q       <= '0;
      stall_cycles <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush) begin
        state <= EMPTY;
      end else begin
        case (state)
          EMPTY: if (accept) begin
            main_q <= in_ent;
            state  <= FULL;
          end
          FULL: begin
            if (accept && drain) begin
              main_q <= in_ent;
            end else if (accept) begin
              skid_q <= in_ent;
              state  <= SKID;
            end else if (drain) begin
              state  <= EMPTY;
            end
          end
          SKID: if (drain) begin
            main_q <= skid_q;
            state  <= FULL;
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

  assign out_alu_data      = main_q.alu_data;
  assign out_store_data    = main_q.store_data;
  assign out_branch_target = main_q.branch_target;
  assign out_zero          = main_q.zero;
  assign out_rd            = main_q.rd;
  assign out_memtoreg      = out_valid & main_q.memtoreg;
  assign out_regwrite      = out_valid & main_q.regwrite;
  assign out_branch        = out_valid & main_q.branch;
  assign out_memread       = out_valid & main_q.memread;
  assign out_memwrite      = out_valid & main_q.memwrite;

  // x0 is hardwired zero, so a write to it must never be forwarded
  assign fwd_rd       = main_q.rd;
  assign fwd_regwrite = out_regwrite & (main_q.rd != '0);

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [63:0] in_alu_data, in_store_data;
  logic [7:0]  in_branch_target;
  logic        in_zero;
  logic [4:0]  in_rd;
  logic        in_memtoreg, in_regwrite, in_branch, in_memread, in_memwrite;

  logic        in_ready, out_valid, out_zero;
  logic [63:0] out_alu_data, out_store_data;
  logic [7:0]  out_branch_target;
  logic [4:0]  out_rd, fwd_rd;
  logic        out_memtoreg, out_regwrite, out_branch, out_memread, out_memwrite, fwd_regwrite;
  logic [15:0] stall_cycles;

  logic        s_in_ready, s_out_valid, s_out_zero;
  logic [63:0] s_out_alu_data, s_out_store_data;
  logic [7:0]  s_out_branch_target;
  logic [4:0]  s_out_rd, s_fwd_rd;
  logic        s_out_memtoreg, s_out_regwrite, s_out_branch, s_out_memread, s_out_memwrite, s_fwd_regwrite;
  logic [1:0]  s_stall_cycles;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_data(in_alu_data), .in_store_data(in_store_data), .in_branch_target(in_branch_target),
    .in_zero(in_zero), .in_rd(in_rd), .in_memtoreg(in_memtoreg), .in_regwrite(in_regwrite),
    .in_branch(in_branch), .in_memread(in_memread), .in_memwrite(in_memwrite),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_data(out_alu_data),
    .out_store_data(out_store_data), .out_branch_target(out_branch_target), .out_zero(out_zero),
    .out_rd(out_rd), .out_memtoreg(out_memtoreg), .out_regwrite(out_regwrite),
    .out_branch(out_branch), .out_memread(out_memread), .out_memwrite(out_memwrite),
    .fwd_rd(fwd_rd), .fwd_regwrite(fwd_regwrite), .stall_cycles(stall_cycles)
  );

  ex_mem_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_alu_data(in_alu_data), .in_store_data(in_store_data), .in_branch_target(in_branch_target),
    .in_zero(in_zero), .in_rd(in_rd), .in_memtoreg(in_memtoreg), .in_regwrite(in_regwrite),
    .in_branch(in_branch), .in_memread(in_memread), .in_memwrite(in_memwrite),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_alu_data(s_out_alu_data),
    .out_store_data(s_out_store_data), .out_branch_target(s_out_branch_target), .out_zero(s_out_zero),
    .out_rd(s_out_rd), .out_memtoreg(s_out_memtoreg), .out_regwrite(s_out_regwrite),
    .out_branch(s_out_branch), .out_memread(s_out_memread), .out_memwrite(s_out_memwrite),
    .fwd_rd(s_fwd_rd), .fwd_regwrite(s_fwd_regwrite), .stall_cycles(s_stall_cycles)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads and stores alternate on rw so gating of both memread and memwrite is exercised
  task automatic drive(input logic v, input logic [63:0] alu, input logic [4:0] rd, input logic rw);
    in_valid         = v;
    in_alu_data      = alu;
    in_store_data    = alu + 64'd1000;
    in_branch_target = alu[7:0] + 8'd4;
    in_zero          = (alu == 64'd0);
    in_rd            = rd;
    in_regwrite      = rw;
    in_memtoreg      = rw;
    in_memread       = rw;
    in_memwrite      = ~rw;
    in_branch        = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 64'd0, 5'd0, 1'b0);
    #1;
    chk("rst_in_ready_during", 64'(in_ready), 64'(0));
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_stall", 64'(stall_cycles), 64'(0));
    chk("rst_alu", out_alu_data, 64'(0));
    chk("rst_regwrite", 64'(out_regwrite), 64'(0));
    rst = 1'b0;
    #1;
    chk("rst_in_ready_after", 64'(in_ready), 64'(1));

    // streaming at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'(10 * (i + 1)), 5'd1, 1'b1);
      tick();
      chk("stream_valid", 64'(out_valid), 64'(1));
      chk("stream_alu", out_alu_data, 64'(10 * (i + 1)));
      chk("stream_in_ready", 64'(in_ready), 64'(1));
    end
    chk("stream_store", out_store_data, 64'd1040);
    chk("stream_target", 64'(out_branch_target), 64'd44);
    drive(1'b0, 64'd0, 5'd0, 1'b0);
    tick();
    chk("stream_empty", 64'(out_valid), 64'(0));
    chk("stream_gate_rw", 64'(out_regwrite), 64'(0));
    chk("stream_stall", 64'(stall_cycles), 64'(0));

    // x0 forwarding suppression
    drive(1'b1, 64'd50, 5'd0, 1'b1);
    tick();
    chk("x0_out_regwrite", 64'(out_regwrite), 64'(1));
    chk("x0_fwd_regwrite", 64'(fwd_regwrite), 64'(0));
    drive(1'b1, 64'd51, 5'd3, 1'b1);
    tick();
    chk("x3_fwd_regwrite", 64'(fwd_regwrite), 64'(1));
    chk("x3_fwd_rd", 64'(fwd_rd), 64'd3);
    drive(1'b0, 64'd0, 5'd0, 1'b0);
    tick();
    chk("x_fwd_empty", 64'(fwd_regwrite), 64'(0));

    // back-pressure into skid
    out_ready = 1'b0;
    drive(1'b1, 64'd5, 5'd5, 1'b1);
    tick();
    chk("bp_a_alu", out_alu_data, 64'd5);
    chk("bp_a_in_ready", 64'(in_ready), 64'(1));
    drive(1'b1, 64'd6, 5'd6, 1'b1);
    tick();
    chk("bp_skid_in_ready", 64'(in_ready), 64'(0));
    drive(1'b0, 64'd0, 5'd0, 1'b0);
    tick();
    chk("bp_stall2", 64'(stall_cycles), 64'd2);
    chk("bp_hold_alu", out_alu_data, 64'd5);
    chk("bp_sat_stall2", 64'(s_stall_cycles), 64'd2);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_no_comb", 64'(in_ready), 64'(0));
    tick();
    chk("bp_b_alu", out_alu_data, 64'd6);
    chk("bp_b_valid", 64'(out_valid), 64'(1));
    chk("bp_in_ready_back", 64'(in_ready), 64'(1));
    chk("bp_stall_hold", 64'(stall_cycles), 64'd2);
    tick();
    chk("bp_drained", 64'(out_valid), 64'(0));

    // flush while in skid, with a same-cycle input that must be discarded
    out_ready = 1'b0;
    drive(1'b1, 64'd11, 5'd7, 1'b0);
    tick();
    drive(1'b1, 64'd12, 5'd8, 1'b0);
    tick();
    chk("fl_skid", 64'(in_ready), 64'(0));
    chk("fl_memwrite_pre", 64'(out_memwrite), 64'(1));
    flush = 1'b1;
    drive(1'b1, 64'd7, 5'd9, 1'b1);
    tick();
    chk("fl_valid", 64'(out_valid), 64'(0));
    chk("fl_memwrite", 64'(out_memwrite), 64'(0));
    chk("fl_memread", 64'(out_memread), 64'(0));
    chk("fl_regwrite", 64'(out_regwrite), 64'(0));
    chk("fl_fwd", 64'(fwd_regwrite), 64'(0));
    flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 64'd0, 5'd0, 1'b0);
    tick();
    chk("fl_no_ghost", 64'(out_valid), 64'(0));
    chk("fl_stall_kept", 64'(stall_cycles), 64'd4);

    // reset while in skid with stall count at 9
    out_ready = 1'b0;
    drive(1'b1, 64'd21, 5'd2, 1'b1);
    tick();
    drive(1'b1, 64'd22, 5'd2, 1'b1);
    tick();
    drive(1'b0, 64'd0, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    chk("rm_stall9", 64'(stall_cycles), 64'd9);
    chk("rm_skid", 64'(in_ready), 64'(0));
    rst = 1'b1;
    drive(1'b1, 64'd99, 5'd4, 1'b1);
    tick();
    chk("rm_valid", 64'(out_valid), 64'(0));
    chk("rm_stall", 64'(stall_cycles), 64'(0));
    chk("rm_alu", out_alu_data, 64'(0));
    chk("rm_store", out_store_data, 64'(0));
    chk("rm_rd", 64'(fwd_rd), 64'(0));
    chk("rm_regwrite", 64'(out_regwrite), 64'(0));
    chk("rm_in_ready_rst", 64'(in_ready), 64'(0));
    rst = 1'b0;
    drive(1'b0, 64'd0, 5'd0, 1'b0);
    #1;
    chk("rm_in_ready", 64'(in_ready), 64'(1));

    // saturation of a 2-bit counter
    drive(1'b1, 64'd1, 5'd1, 1'b1);
    tick();
    drive(1'b0, 64'd0, 5'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("sat_small", 64'(s_stall_cycles), 64'((i + 1 > 3) ? 3 : i + 1));
      chk("sat_wide", 64'(stall_cycles), 64'(i + 1));
    end
    out_ready = 1'b1;
    tick();
    chk("sat_drain", 64'(out_valid), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
